// File: rtl/seq_det_pkg.sv
// seq_det shared types: FSM state encoding and its width.
package seq_det_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_MATCH  = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

endpackage

// File: rtl/seq_det_if.sv
// seq_det symbol stream: valid-qualified symbols, no ready (the detector never stalls).
interface seq_det_if
   import seq_det_pkg::*;
#(
   parameter int SYM_W = 2
) ();

   logic             in_valid;
   logic [SYM_W-1:0] in_sym;

   modport master (output in_valid, output in_sym);
   modport slave  (input  in_valid, input  in_sym);

endinterface

// File: rtl/seq_det_window.sv
// seq_det_window: last-PAT_LEN symbol history, fill counter and pattern compare.
// hit is combinational on the accepted symbol; history/fill update on the same edge.
module seq_det_window
   import seq_det_pkg::*;
#(
   parameter int SYM_W   = 2,
   parameter int PAT_LEN = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     accept,
   input  logic [SYM_W-1:0]         in_sym,
   input  logic [SYM_W*PAT_LEN-1:0] pattern,
   input  logic [PAT_LEN-1:0]       mask,
   input  logic                     clr_fill,
   input  logic                     restart,
   output logic                     hit
);

   localparam int HIST_W = SYM_W * PAT_LEN;
   localparam int FILL_W = $clog2(PAT_LEN + 1);

   logic [HIST_W-1:0] hist_q, hist_d, cand;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              eq;

   // Slot 0 (LSBs) is the oldest symbol; the new symbol enters the top slot.
   always_comb begin
      cand = {in_sym, hist_q[HIST_W-1:SYM_W]};
      eq   = 1'b1;
      for (int k = 0; k < PAT_LEN; k++) begin
         if (!mask[k] && (cand[k*SYM_W +: SYM_W] != pattern[k*SYM_W +: SYM_W]))
            eq = 1'b0;
      end
      hit = accept && (fill_q >= FILL_W'(PAT_LEN - 1)) && eq;
   end

   always_comb begin
      hist_d = accept ? cand : hist_q;
      fill_d = fill_q;
      if (clr_fill)
         fill_d = '0;
      else if (accept) begin
         if (restart)
            fill_d = '0;
         else if (fill_q != FILL_W'(PAT_LEN))
            fill_d = fill_q + FILL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_det.sv
// seq_det: programmable Moore sequence detector; define SEQ_DET_MASK_EN for a per-slot don't-care mask.
// match is registered one cycle after the completing symbol; the input stream is never stalled.
module seq_det
   import seq_det_pkg::*;
#(
   parameter int SYM_W   = 2,
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_we,
   input  logic [SYM_W*PAT_LEN-1:0] cfg_pattern,
   input  logic                     cfg_overlap,
   input  logic                     cfg_sticky,
`ifdef SEQ_DET_MASK_EN
   input  logic [PAT_LEN-1:0]       cfg_mask,
`endif
   input  logic                     arm,
   input  logic                     disarm,
   input  logic                     clear,
   seq_det_if.slave                 sin,
   output logic                     match,
   output logic [CNT_W-1:0]         match_cnt,
   output logic [ST_W-1:0]          state
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e                   state_q, state_d;
   logic                     match_q, match_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [SYM_W*PAT_LEN-1:0] pat_q, pat_d;
   logic                     ovl_q, ovl_d;
   logic                     sticky_q, sticky_d;
   logic [PAT_LEN-1:0]       mask_w;
   logic                     accept, hit, hit_take, clr_fill, restart, cfg_load;

`ifdef SEQ_DET_MASK_EN
   logic [PAT_LEN-1:0] mask_q, mask_d;

   always_comb begin
      mask_d = mask_q;
      if (cfg_load)
         mask_d = cfg_mask;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mask_q <= '0;
      else       mask_q <= mask_d;
   end

   assign mask_w = mask_q;
`else
   assign mask_w = '0;
`endif

   // disarm outranks clear, which outranks a hit; a suppressed hit neither counts nor restarts the window.
   always_comb begin
      accept   = sin.in_valid && (state_q != ST_IDLE);
      cfg_load = cfg_we && (state_q == ST_IDLE);
      clr_fill = arm && !disarm && (state_q == ST_IDLE);
      hit_take = hit && !disarm && !clear;
      restart  = hit_take && !ovl_q;
   end

   always_comb begin
      pat_d    = pat_q;
      ovl_d    = ovl_q;
      sticky_d = sticky_q;
      if (cfg_load) begin
         pat_d    = cfg_pattern;
         ovl_d    = cfg_overlap;
         sticky_d = cfg_sticky;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (disarm)
         state_d = ST_IDLE;
      else begin
         if (clear)
            cnt_d = '0;
         else if (hit_take && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
         case (state_q)
            ST_IDLE:   if (arm) state_d = ST_SEARCH;
            ST_SEARCH,
            ST_MATCH: begin
               if (hit_take) state_d = sticky_q ? ST_HOLD : ST_MATCH;
               else          state_d = ST_SEARCH;
            end
            ST_HOLD:   if (clear) state_d = ST_SEARCH;
            default:   state_d = ST_IDLE;
         endcase
      end
      match_d = (state_d == ST_MATCH) || (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         match_q  <= 1'b0;
         cnt_q    <= '0;
         pat_q    <= '0;
         ovl_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         match_q  <= match_d;
         cnt_q    <= cnt_d;
         pat_q    <= pat_d;
         ovl_q    <= ovl_d;
         sticky_q <= sticky_d;
      end
   end

   seq_det_window #(
      .SYM_W   (SYM_W),
      .PAT_LEN (PAT_LEN)
   ) u_win (
      .clk      (clk),
      .reset    (reset),
      .accept   (accept),
      .in_sym   (sin.in_sym),
      .pattern  (pat_q),
      .mask     (mask_w),
      .clr_fill (clr_fill),
      .restart  (restart),
      .hit      (hit)
   );

   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign state     = state_q;

endmodule

// File: tb/tb_seq_det.sv
// Bench for seq_det (SYM_W=2, PAT_LEN=3); a second instance with CNT_W=2 covers saturation.
module tb_seq_det;
   import seq_det_pkg::*;

   localparam int SYM_W   = 2;
   localparam int PAT_LEN = 3;

   logic clk = 1'b0;
   logic reset;
   logic cfg_we, cfg_overlap, cfg_sticky, arm, disarm, clear;
   logic [SYM_W*PAT_LEN-1:0] cfg_pattern;
`ifdef SEQ_DET_MASK_EN
   logic [PAT_LEN-1:0] cfg_mask;
`endif
   logic            match, match_s;
   logic [7:0]      match_cnt;
   logic [1:0]      cnt_s;
   logic [ST_W-1:0] state, state_s;

   typedef struct packed {
      logic       m;
      logic [7:0] cnt;
      logic [1:0] st;
      logic [1:0] cs;
   } exp_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   seq_det_if #(.SYM_W(SYM_W)) sif ();

   seq_det #(.SYM_W(SYM_W), .PAT_LEN(PAT_LEN), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_overlap(cfg_overlap), .cfg_sticky(cfg_sticky),
`ifdef SEQ_DET_MASK_EN
      .cfg_mask(cfg_mask),
`endif
      .arm(arm), .disarm(disarm), .clear(clear), .sin(sif.slave),
      .match(match), .match_cnt(match_cnt), .state(state)
   );

   seq_det #(.SYM_W(SYM_W), .PAT_LEN(PAT_LEN), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_overlap(cfg_overlap), .cfg_sticky(cfg_sticky),
`ifdef SEQ_DET_MASK_EN
      .cfg_mask(cfg_mask),
`endif
      .arm(arm), .disarm(disarm), .clear(clear), .sin(sif.slave),
      .match(match_s), .match_cnt(cnt_s), .state(state_s)
   );

   function automatic logic [5:0] pat3(input int a, input int b, input int c);
      return {2'(c), 2'(b), 2'(a)};
   endfunction

   // One clock: inputs applied at a falling edge, outputs visible at the next falling edge.
   task automatic cyc(input logic v, input logic [1:0] s, input int ctl);
      sif.in_valid = v;
      sif.in_sym   = s;
      cfg_we = ctl[0];
      arm    = ctl[1];
      disarm = ctl[2];
      clear  = ctl[3];
      @(posedge clk);
      @(negedge clk);
      sif.in_valid = 1'b0;
      cfg_we = 1'b0; arm = 1'b0; disarm = 1'b0; clear = 1'b0;
   endtask

   task automatic push_exp(input int m, input int c, input int st, input int cs);
      exp_t e;
      e.m = (m != 0); e.cnt = 8'(c); e.st = 2'(st); e.cs = 2'(cs);
      exp_q.push_back(e);
   endtask

   task automatic setup(input logic [5:0] pat, input logic ov, input logic st);
      cyc(1'b0, 2'd0, 4);
      cfg_pattern = pat; cfg_overlap = ov; cfg_sticky = st;
      cyc(1'b0, 2'd0, 9);
      cyc(1'b0, 2'd0, 2);
   endtask

   task automatic test_reset();
      exp_t e;
      reset = 1'b1;
      sif.in_valid = 1'b0; sif.in_sym = '0;
      cfg_we = 0; arm = 0; disarm = 0; clear = 0;
      cfg_pattern = '0; cfg_overlap = 0; cfg_sticky = 0;
`ifdef SEQ_DET_MASK_EN
      cfg_mask = '0;
`endif
      push_exp(0, 0, 0, 0);
      @(negedge clk); @(negedge clk);
      e = exp_q.pop_front();
      n_total++;
      if (match !== e.m || match_cnt !== e.cnt || state !== e.st || cnt_s !== e.cs)
         $display("FAIL reset: got match=%0b cnt=%0d state=%0d cnt_s=%0d, want %0b %0d %0d %0d",
                  match, match_cnt, state, cnt_s, e.m, e.cnt, e.st, e.cs);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int s[4]  = '{1, 2, 3, 0};
      int v[4]  = '{1, 1, 1, 0};
      int em[4] = '{0, 0, 1, 0};
      int ec[4] = '{0, 0, 1, 1};
      int es[4] = '{1, 1, 2, 1};
      exp_t e;
      setup(pat3(1, 2, 3), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         push_exp(em[i], ec[i], es[i], 0);
         cyc(v[i][0], 2'(s[i]), 0);
         e = exp_q.pop_front();
         n_total++;
         if (match !== e.m || match_cnt !== e.cnt || state !== e.st)
            $display("FAIL basic step %0d: got match=%0b cnt=%0d state=%0d, want %0b %0d %0d",
                     i, match, match_cnt, state, e.m, e.cnt, e.st);
         else n_pass++;
      end
   endtask

   task automatic test_overlap();
      int em1[7] = '{0, 0, 1, 1, 1, 1, 0};
      int ec1[7] = '{0, 0, 1, 2, 3, 4, 4};
      int es1[7] = '{1, 1, 2, 2, 2, 2, 1};
      int em0[7] = '{0, 0, 1, 0, 0, 1, 0};
      int ec0[7] = '{0, 0, 1, 1, 1, 2, 2};
      int es0[7] = '{1, 1, 2, 1, 1, 2, 1};
      exp_t e;
      for (int ov = 1; ov >= 0; ov--) begin
         setup(pat3(1, 1, 1), ov[0], 1'b0);
         for (int i = 0; i < 7; i++) begin
            if (ov == 1) push_exp(em1[i], ec1[i], es1[i], 0);
            else         push_exp(em0[i], ec0[i], es0[i], 0);
            cyc(i < 6, 2'd1, 0);
            e = exp_q.pop_front();
            n_total++;
            if (match !== e.m || match_cnt !== e.cnt || state !== e.st)
               $display("FAIL overlap=%0d step %0d: got match=%0b cnt=%0d state=%0d, want %0b %0d %0d",
                        ov, i, match, match_cnt, state, e.m, e.cnt, e.st);
            else n_pass++;
         end
      end
   endtask

   task automatic test_gaps();
      int v[11]  = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};
      int s[11]  = '{1, 3, 2, 3, 3, 3, 0, 1, 2, 0, 3};
      int em[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      int ec[11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
      int es[11] = '{1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1};
      exp_t e;
      setup(pat3(1, 2, 3), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) begin
         push_exp(em[i], ec[i], es[i], 0);
         cyc(v[i][0], 2'(s[i]), 0);
         e = exp_q.pop_front();
         n_total++;
         if (match !== e.m || match_cnt !== e.cnt || state !== e.st)
            $display("FAIL gaps step %0d: got match=%0b cnt=%0d state=%0d, want %0b %0d %0d",
                     i, match, match_cnt, state, e.m, e.cnt, e.st);
         else n_pass++;
      end
   endtask

   task automatic test_sticky();
      int v[20]   = '{1,1,1, 0,0,0,0,0,0,0,0,0,0, 1,1,1, 1,1,1, 0};
      int s[20]   = '{1,2,3, 1,1,1,1,1,1,1,1,1,1, 1,2,3, 1,2,3, 0};
      int ctl[20] = '{0,0,0, 0,0,0,0,0,0,0,0,0,0, 0,0,0, 0,0,8, 0};
      int em[20]  = '{0,0,1, 1,1,1,1,1,1,1,1,1,1, 1,1,1, 1,1,0, 0};
      int ec[20]  = '{0,0,1, 1,1,1,1,1,1,1,1,1,1, 1,1,2, 2,2,0, 0};
      int es[20]  = '{1,1,3, 3,3,3,3,3,3,3,3,3,3, 3,3,3, 3,3,1, 1};
      exp_t e;
      setup(pat3(1, 2, 3), 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         push_exp(em[i], ec[i], es[i], 0);
         cyc(v[i][0], 2'(s[i]), ctl[i]);
         e = exp_q.pop_front();
         n_total++;
         if (match !== e.m || match_cnt !== e.cnt || state !== e.st)
            $display("FAIL sticky step %0d: got match=%0b cnt=%0d state=%0d, want %0b %0d %0d",
                     i, match, match_cnt, state, e.m, e.cnt, e.st);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      int s[7] = '{1, 2, 3, 1, 2, 3, 0};
      exp_t e;
      setup(pat3(1, 2, 3), 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 2'(s[i]), 0);
      push_exp(1, 1, 3, 1);
      e = exp_q.pop_front();
      n_total++;
      if (match !== e.m || match_cnt !== e.cnt || state !== e.st)
         $display("FAIL pre_reset: got match=%0b cnt=%0d state=%0d, want %0b %0d %0d",
                  match, match_cnt, state, e.m, e.cnt, e.st);
      else n_pass++;
      // Reset lands between clock edges, after the 2nd symbol of the second sequence.
      #2 reset = 1'b1;
      push_exp(0, 0, 0, 0);
      #1;
      e = exp_q.pop_front();
      n_total++;
      if (match !== e.m || match_cnt !== e.cnt || state !== e.st || cnt_s !== e.cs)
         $display("FAIL async_reset: got match=%0b cnt=%0d state=%0d cnt_s=%0d, want %0b %0d %0d %0d",
                  match, match_cnt, state, cnt_s, e.m, e.cnt, e.st, e.cs);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      setup(pat3(1, 2, 3), 1'b0, 1'b0);
      for (int i = 5; i < 7; i++) begin
         push_exp(0, 0, 1, 0);
         cyc(i == 5, 2'(s[i]), 0);
         e = exp_q.pop_front();
         n_total++;
         if (match !== e.m || match_cnt !== e.cnt || state !== e.st)
            $display("FAIL rearm step %0d: got match=%0b cnt=%0d state=%0d, want %0b %0d %0d",
                     i, match, match_cnt, state, e.m, e.cnt, e.st);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      int s[3] = '{1, 2, 3};
      int c;
      exp_t e;
      setup(pat3(1, 2, 3), 1'b0, 1'b0);
      for (int rep = 1; rep <= 5; rep++) begin
         for (int j = 0; j < 3; j++) begin
            c = (j == 2) ? rep : rep - 1;
            push_exp(j == 2, c, (j == 2) ? 2 : 1, (c > 3) ? 3 : c);
            cyc(1'b1, 2'(s[j]), 0);
            e = exp_q.pop_front();
            n_total++;
            if (match !== e.m || match_cnt !== e.cnt || state !== e.st || cnt_s !== e.cs || match_s !== e.m)
               $display("FAIL saturation rep %0d sym %0d: got match=%0b cnt=%0d state=%0d cnt_s=%0d match_s=%0b, want %0b %0d %0d %0d",
                        rep, j, match, match_cnt, state, cnt_s, match_s, e.m, e.cnt, e.st, e.cs);
            else n_pass++;
         end
      end
   endtask

   task automatic test_cfg_locked();
      int v[11]   = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
      int s[11]   = '{0, 3, 3, 3, 1, 2, 3, 0, 1, 2, 3};
      int ctl[11] = '{1, 0, 0, 0, 0, 2, 0, 6, 0, 0, 0};
      int em[11]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      int ec[11]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
      int es[11]  = '{1, 1, 1, 1, 1, 1, 2, 0, 0, 0, 0};
      exp_t e;
      setup(pat3(1, 2, 3), 1'b0, 1'b0);
      cfg_pattern = pat3(3, 3, 3);
      cfg_sticky  = 1'b1;
      for (int i = 0; i < 11; i++) begin
         push_exp(em[i], ec[i], es[i], 0);
         cyc(v[i][0], 2'(s[i]), ctl[i]);
         e = exp_q.pop_front();
         n_total++;
         if (match !== e.m || match_cnt !== e.cnt || state !== e.st)
            $display("FAIL cfg_locked step %0d: got match=%0b cnt=%0d state=%0d, want %0b %0d %0d",
                     i, match, match_cnt, state, e.m, e.cnt, e.st);
         else n_pass++;
      end
   endtask

`ifdef SEQ_DET_MASK_EN
   task automatic test_mask();
      int s[4]  = '{1, 0, 3, 0};
      int em[4] = '{0, 0, 1, 0};
      int ec[4] = '{0, 0, 1, 1};
      int es[4] = '{1, 1, 2, 1};
      exp_t e;
      cfg_mask = 3'b010;
      setup(pat3(1, 2, 3), 1'b0, 1'b0);
      cfg_mask = 3'b000;
      for (int i = 0; i < 4; i++) begin
         push_exp(em[i], ec[i], es[i], 0);
         cyc(i < 3, 2'(s[i]), 0);
         e = exp_q.pop_front();
         n_total++;
         if (match !== e.m || match_cnt !== e.cnt || state !== e.st)
            $display("FAIL mask step %0d: got match=%0b cnt=%0d state=%0d, want %0b %0d %0d",
                     i, match, match_cnt, state, e.m, e.cnt, e.st);
         else n_pass++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overlap();
      test_gaps();
      test_sticky();
      test_async_reset();
      test_saturation();
      test_cfg_locked();
`ifdef SEQ_DET_MASK_EN
      test_mask();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
